rf_wb_sched: RTL

//  Write-back scheduler for the 32x32 register file's single write port: round-robin arbitration

---
 rtl/rf_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/rf_wb_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rf_sched_pkg.sv
// Shared constants for the register-file write-back path.
//   RF_AW / RF_DW : register file address / data widths
//   RF_NREG       : number of architectural registers (reg 0 is hard-wired zero)
//   REQ_*         : fixed requester indices on the write-back arbiter
package rf_sched_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;
    localparam int RF_NREG = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk    : clock
//   rst    : asynchronous active-high reset; pointer returns to NREQ-1
//   req_i  : request vector
//   adv_i  : a grant was consumed this cycle; move the pointer to the winner
//   gnt_o  : one-hot grant (combinational), zero when nothing requests
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] idx;
    logic          found;

    // Search begins one past the last winner, so the last winner is lowest priority.
    always_comb begin
        gnt_o   = '0;
        gnt_idx = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    // Pointer is only touched in the sequential block, which keeps adv_i
    // (derived from gnt_o by the parent) out of any combinational loop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PW'(NREQ - 1);
        end else if (adv_i) begin
            ptr_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler for the register file's single write port.
// Arbitrates NREQ producers round-robin, registers the winner onto the RF
// write port, and tracks outstanding writes per register for the hazard unit.
//   clk, rst_n          : clock; rst_n is an ACTIVE-HIGH asynchronous reset
//   req_valid_i/wa/wd   : requester valid, dest reg ([5i+4:5i]), data ([32i+31:32i])
//   req_ready_o         : one-hot grant; transfer when valid & ready
//   rf_we_o/wa_o/wd_o   : registered RF write port
//   sb_set_i/sb_set_wa_i: issue stage announces a future write to sb_set_wa_i
//   sb_q0_i/sb_q1_i     : scoreboard query addresses
//   sb_busy0_o/1_o      : queried register has an uncommitted write
//   sb_err_o            : sticky, a set hit a saturated counter
module rf_wb_sched #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*5-1:0] req_wa_i,
    input  logic [NREQ*32-1:0] req_wd_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              rf_we_o,
    output logic [4:0]        rf_wa_o,
    output logic [31:0]       rf_wd_o,
    input  logic              sb_set_i,
    input  logic [4:0]        sb_set_wa_i,
    input  logic [4:0]        sb_q0_i,
    input  logic [4:0]        sb_q1_i,
    output logic              sb_busy0_o,
    output logic              sb_busy1_o,
    output logic              sb_err_o
);

    import rf_sched_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREQ-1:0]  gnt;
    logic             xfer;
    logic [RF_AW-1:0] sel_wa;
    logic [RF_DW-1:0] sel_wd;

    logic             rf_we_q;
    logic [RF_AW-1:0] rf_wa_q;
    logic [RF_DW-1:0] rf_wd_q;

    logic [CNT_W-1:0] cnt_q [RF_NREG];
    logic [CNT_W-1:0] cnt_d [RF_NREG];
    logic             err_q;
    logic             err_d;
    logic             set_hit;
    logic             com_hit;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst_n),
        .req_i (req_valid_i),
        .adv_i (xfer),
        .gnt_o (gnt)
    );

    assign req_ready_o = gnt;
    assign xfer        = |(req_valid_i & gnt);

    always_comb begin
        sel_wa = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_wa = req_wa_i[RF_AW*i +: RF_AW];
                sel_wd = req_wd_i[RF_DW*i +: RF_DW];
            end
        end
    end

    // Output stage. Writes to reg 0 complete the handshake but never assert we,
    // which also keeps them off the scoreboard's commit path.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= xfer && (sel_wa != '0);
            if (xfer) begin
                rf_wa_q <= sel_wa;
                rf_wd_q <= sel_wd;
            end
        end
    end

    assign rf_we_o = rf_we_q;
    assign rf_wa_o = rf_wa_q;
    assign rf_wd_o = rf_wd_q;

    // Scoreboard. A commit is the cycle the write sits on the RF port; a
    // same-cycle set and commit cancel. Commits on an empty counter are from
    // untracked producers and are simply absorbed.
    always_comb begin
        err_d   = err_q;
        set_hit = 1'b0;
        com_hit = 1'b0;
        for (int r = 0; r < RF_NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            set_hit  = sb_set_i && (sb_set_wa_i == RF_AW'(r));
            com_hit  = rf_we_q && (rf_wa_q == RF_AW'(r));
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (set_hit && !com_hit) begin
                if (cnt_q[r] == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end
            end else if (com_hit && !set_hit && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err_q <= 1'b0;
            for (int r = 0; r < RF_NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int r = 0; r < RF_NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign sb_busy0_o = (sb_q0_i != '0) && (cnt_q[sb_q0_i] != '0);
    assign sb_busy1_o = (sb_q1_i != '0) && (cnt_q[sb_q1_i] != '0);
    assign sb_err_o   = err_q;

endmodule
